// File: rtl/lc3_mem_arb.sv
// Arbiter sharing one single-port synchronous memory between the LC3 CPU port and a loader port.
// Define MEM_ARB_RR_EN for round-robin arbitration instead of CPU priority with loader aging.
module lc3_mem_arb #(
   parameter int unsigned ADDR_W  = 16,
   parameter int unsigned DATA_W  = 16,
   parameter int unsigned MEM_LAT = 2,
   parameter int unsigned AGE_MAX = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_done,
   input  logic              ldr_req,
   input  logic              ldr_we,
   input  logic [ADDR_W-1:0] ldr_addr,
   input  logic [DATA_W-1:0] ldr_wdata,
   output logic [DATA_W-1:0] ldr_rdata,
   output logic              ldr_done,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);

   typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

   state_e              state_q, state_d;
   logic [3:0]          cnt_q, cnt_d;
   logic                owner_q;  // 1 = loader owns the transaction in flight
   logic                we_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [DATA_W-1:0]   cpu_rdata_q, ldr_rdata_q;
   logic                cpu_done_q, ldr_done_q;
   logic                cpu_el, ldr_el, grant, grant_ldr, last_beat;

   // A port whose done is high still shows the req of its finished transaction.
   assign cpu_el    = cpu_req & ~cpu_done_q;
   assign ldr_el    = ldr_req & ~ldr_done_q;
   assign grant     = (state_q == StIdle) & (cpu_el | ldr_el);
   assign last_beat = (state_q == StWait) && (cnt_q == 4'd1);

`ifdef MEM_ARB_RR_EN
   logic last_ldr_q;

   assign grant_ldr = ldr_el & (~cpu_el | ~last_ldr_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_ldr_q <= 1'b1;
      end else if (grant) begin
         last_ldr_q <= grant_ldr;
      end
   end
`else
   logic [7:0] age_q;

   assign grant_ldr = ldr_el & (~cpu_el | (age_q == 8'(AGE_MAX)));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         age_q <= '0;
      end else if (!ldr_req || (grant && grant_ldr)) begin
         age_q <= '0;
      end else if (grant) begin
         age_q <= age_q + 8'd1;
      end
   end
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIdle: begin
            if (grant) state_d = StIssue;
         end
         StIssue: begin
            state_d = StWait;
            cnt_d   = 4'(MEM_LAT);
         end
         StWait: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         owner_q     <= 1'b0;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         cpu_rdata_q <= '0;
         ldr_rdata_q <= '0;
         cpu_done_q  <= 1'b0;
         ldr_done_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         cpu_done_q <= last_beat & ~owner_q;
         ldr_done_q <= last_beat & owner_q;
         if (grant) begin
            owner_q <= grant_ldr;
            we_q    <= grant_ldr ? ldr_we    : cpu_we;
            addr_q  <= grant_ldr ? ldr_addr  : cpu_addr;
            wdata_q <= grant_ldr ? ldr_wdata : cpu_wdata;
         end
         if (last_beat && !we_q) begin
            if (owner_q) ldr_rdata_q <= mem_rdata;
            else         cpu_rdata_q <= mem_rdata;
         end
      end
   end

   assign mem_en    = (state_q == StIssue);
   assign mem_we    = we_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign busy      = (state_q != StIdle);
   assign cpu_rdata = cpu_rdata_q;
   assign ldr_rdata = ldr_rdata_q;
   assign cpu_done  = cpu_done_q;
   assign ldr_done  = ldr_done_q;

endmodule
